// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA drawing definitions used by the map drawer, the sprite drawer
// and the plot arbiter: pixel field widths, default screen limits, the
// arbiter state encoding and a pixel range check.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 3;

  // Default 320x240 screen: highest legal coordinates.
  localparam int X_MAX_DEFAULT = 319;
  localparam int Y_MAX_DEFAULT = 239;

  // The encoding doubles as the grant output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MAP  = 2'b01,
    ST_SPR  = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  function automatic logic pixel_in_range(input pixel_t p, input int x_max, input int y_max);
    return (int'(p.x) <= x_max) && (int'(p.y) <= y_max);
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_plot_arbiter_if
// Bundles the two requester pixel handshakes (map drawer, sprite drawer) and
// the registered VGA-adapter write port of the plot arbiter.
//   map_* / spr_* : valid/ready/last handshake plus x, y, color of a pixel
//   plot, X, Y, color : VGA-adapter write strobe and pixel
//   grant         : current owner (00 none, 01 map, 10 sprite)
//   dropped       : pulse for an accepted pixel that was off screen
// Modports:
//   slave  - the arbiter's view (receives pixels, drives the adapter port)
//   master - the requesters' / adapter-side view
// ---------------------------------------------------------------------------
interface vga_plot_arbiter_if;

  logic                        map_valid;
  logic                        map_ready;
  logic                        map_last;
  logic [vga_pkg::X_W-1:0]     map_x;
  logic [vga_pkg::Y_W-1:0]     map_y;
  logic [vga_pkg::COLOR_W-1:0] map_color;

  logic                        spr_valid;
  logic                        spr_ready;
  logic                        spr_last;
  logic [vga_pkg::X_W-1:0]     spr_x;
  logic [vga_pkg::Y_W-1:0]     spr_y;
  logic [vga_pkg::COLOR_W-1:0] spr_color;

  logic                        plot;
  logic [vga_pkg::X_W-1:0]     X;
  logic [vga_pkg::Y_W-1:0]     Y;
  logic [vga_pkg::COLOR_W-1:0] color;
  logic [1:0]                  grant;
  logic                        dropped;

  modport slave (
    input  map_valid, map_last, map_x, map_y, map_color,
    input  spr_valid, spr_last, spr_x, spr_y, spr_color,
    output map_ready, spr_ready,
    output plot, X, Y, color, grant, dropped
  );

  modport master (
    output map_valid, map_last, map_x, map_y, map_color,
    output spr_valid, spr_last, spr_x, spr_y, spr_color,
    input  map_ready, spr_ready,
    input  plot, X, Y, color, grant, dropped
  );

endinterface

// File: rtl/vga_pixel_reg.sv
// ---------------------------------------------------------------------------
// vga_pixel_reg
// Registered output stage of the plot arbiter. An accepted pixel that lies on
// screen is presented on the adapter port one cycle later with plot=1; an
// off-screen pixel produces a one-cycle dropped pulse instead. The pixel
// registers only load on a real plot, so X/Y/color hold otherwise.
// Ports:
//   clock, resetn        : clock and synchronous active-low reset
//   beat_valid, beat     : pixel accepted on this edge
//   plot, dropped, pix   : registered adapter outputs
// ---------------------------------------------------------------------------
module vga_pixel_reg
  import vga_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEFAULT,
  parameter int Y_MAX = Y_MAX_DEFAULT
) (
  input  logic   clock,
  input  logic   resetn,
  input  logic   beat_valid,
  input  pixel_t beat,
  output logic   plot,
  output logic   dropped,
  output pixel_t pix
);

  logic in_range;

  assign in_range = pixel_in_range(beat, X_MAX, Y_MAX);

  // Off-screen pixels are still consumed upstream; here they only turn into
  // a dropped pulse and never disturb the held pixel value.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      plot    <= 1'b0;
      dropped <= 1'b0;
      pix     <= '0;
    end else begin
      plot    <= beat_valid && in_range;
      dropped <= beat_valid && !in_range;
      if (beat_valid && in_range) begin
        pix <= beat;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// ---------------------------------------------------------------------------
// vga_plot_arbiter
// Shares one VGA-adapter write port between the map drawer and the sprite
// drawer. Map wins simultaneous requests; an owner keeps the port until its
// last pixel, until it has sent MAX_BURST pixels while the other side waits,
// or until it goes quiet while the other side waits.
// Parameters: MAX_BURST, X_MAX, Y_MAX
// Ports:
//   clock, resetn : clock and synchronous active-low reset
//   bus           : vga_plot_arbiter_if.slave (requesters + adapter port)
// ---------------------------------------------------------------------------
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int X_MAX     = X_MAX_DEFAULT,
  parameter int Y_MAX     = Y_MAX_DEFAULT
) (
  input logic         clock,
  input logic         resetn,
  vga_plot_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state;
  arb_state_t       state_next;
  arb_state_t       other_state;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             own_valid;
  logic             own_last;
  logic             other_valid;
  logic             accept;
  logic             leave;
  pixel_t           beat;
  pixel_t           pix;
  logic             plot;
  logic             dropped;

  // Select the owner's handshake and pixel, and the competing requester.
  always_comb begin
    own_valid   = 1'b0;
    own_last    = 1'b0;
    other_valid = 1'b0;
    other_state = ST_IDLE;
    beat        = '0;
    unique case (state)
      ST_MAP: begin
        own_valid   = bus.map_valid;
        own_last    = bus.map_last;
        other_valid = bus.spr_valid;
        other_state = ST_SPR;
        beat        = '{x: bus.map_x, y: bus.map_y, color: bus.map_color};
      end
      ST_SPR: begin
        own_valid   = bus.spr_valid;
        own_last    = bus.spr_last;
        other_valid = bus.map_valid;
        other_state = ST_MAP;
        beat        = '{x: bus.spr_x, y: bus.spr_y, color: bus.spr_color};
      end
      default: begin
        own_valid   = 1'b0;
      end
    endcase
  end

  // Ready is a pure state decode, so acceptance is just the owner's valid.
  assign accept  = resetn && (state != ST_IDLE) && own_valid;

  // Counter value after this edge; it saturates instead of wrapping.
  assign cnt_inc = (accept && (burst_cnt != CNT_MAX)) ? burst_cnt + CNT_W'(1) : burst_cnt;

  // Yield conditions are judged on the post-edge count, so the beat that
  // completes the burst is still taken before the port changes hands.
  assign leave = (accept && own_last)
              || ((cnt_inc == CNT_MAX) && other_valid)
              || (!own_valid && other_valid);

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.map_valid) begin
          state_next = ST_MAP;
        end else if (bus.spr_valid) begin
          state_next = ST_SPR;
        end
      end
      ST_MAP, ST_SPR: begin
        if (leave) begin
          state_next = other_valid ? other_state : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Burst counter: restarts on every state entry, holds while the owner idles.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      burst_cnt <= '0;
    end else if (state_next != state) begin
      burst_cnt <= '0;
    end else begin
      burst_cnt <= cnt_inc;
    end
  end

  // Output decode. The readies are also forced low by resetn so nothing is
  // handed over in a cycle whose edge is about to reset the arbiter.
  always_comb begin
    bus.map_ready = resetn && (state == ST_MAP);
    bus.spr_ready = resetn && (state == ST_SPR);
    bus.grant     = state;
  end

  vga_pixel_reg #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_pixel_reg (
    .clock      (clock),
    .resetn     (resetn),
    .beat_valid (accept),
    .beat       (beat),
    .plot       (plot),
    .dropped    (dropped),
    .pix        (pix)
  );

  assign bus.plot    = plot;
  assign bus.dropped = dropped;
  assign bus.X       = pix.x;
  assign bus.Y       = pix.y;
  assign bus.color   = pix.color;

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16: pixels one requester may send before it must yield to a waiting requester.
REQ-002 Parameter X_MAX, default 319: highest legal X coordinate.
REQ-003 Parameter Y_MAX, default 239: highest legal Y coordinate.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 map_valid / map_ready / map_last  in / out / in  1 each  map-drawer pixel handshake; last marks the final pixel of a redraw.
REQ-007 map_x / map_y / map_color  in  9 / 8 / 3  map-drawer pixel.
REQ-008 spr_valid / spr_ready / spr_last  in / out / in  1 each  sprite pixel handshake; last marks the final pixel of a sprite draw or erase.
REQ-009 spr_x / spr_y / spr_color  in  9 / 8 / 3  sprite pixel.
REQ-010 plot / X / Y / color  out  1 / 9 / 8 / 3  registered VGA-adapter write port.
REQ-011 grant  out  2  current owner: 00 none, 01 map, 10 sprite.
REQ-012 dropped  out  1  one-cycle pulse when an accepted pixel is out of range.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, MAP, SPR; grant SHALL encode the state.
REQ-014 In IDLE, both readies SHALL be 0; next state is MAP if map_valid=1, else SPR if spr_valid=1, else IDLE. Map wins simultaneous requests.
REQ-015 In MAP, map_ready SHALL be 1 and spr_ready 0. In SPR, the reverse SHALL hold.
REQ-016 A beat SHALL be accepted when the granted valid and ready are both 1 on a clock edge. At most one beat is accepted per cycle.
REQ-017 An accepted in-range beat SHALL drive plot=1 with X/Y/color equal to the beat's values on the next cycle (latency 1).
REQ-018 In every other cycle, plot SHALL be 0 and X/Y/color SHALL hold their last values.
REQ-019 A beat with x>X_MAX or y>Y_MAX SHALL be accepted and counted, but plot SHALL stay 0 and dropped SHALL pulse 1 on the next cycle.
REQ-020 A burst counter of clog2(MAX_BURST)+1 bits SHALL clear on every state entry and increment on each accepted beat, saturating at MAX_BURST.
REQ-021 Leaving the granted state SHALL occur after the edge on which either condition holds:
  - (a) an accepted beat has last=1;
  - (b) counter=MAX_BURST and the other valid=1;
  - (c) the granted valid=0 and the other valid=1.
REQ-022 On leaving, the next state SHALL be the other requester's state if its valid=1, else IDLE. When (a) and (b) hold together, the transition is the same.
REQ-023 While the granted valid=0 and the other valid=0, the FSM SHALL remain in the granted state with the counter held.
REQ-024 Condition (b) SHALL never cut off a beat: the beat that brings the counter to MAX_BURST is fully output before the switch.
REQ-025 The arbiter SHALL NOT alter, reorder or duplicate pixels. Each accepted beat yields exactly one plot or one dropped pulse.

Reset
REQ-026 With resetn=0 at an edge: state IDLE, counter 0, plot 0, X 0, Y 0, color 0, dropped 0, grant 00.
REQ-027 Readies SHALL be 0 throughout the reset cycle.
REQ-028 A burst interrupted by reset SHALL be abandoned. A beat presented in the reset cycle SHALL NOT be plotted.

Structure
REQ-029 The state encoding and the default X_MAX/Y_MAX screen constants SHALL live in shared package vga_pkg, reused by the map and sprite drawers.
REQ-030 The block SHALL be one module plus an optional sub-module vga_pixel_reg. vga_pixel_reg holds the registered output stage and range check.
REQ-031 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from input to output.

Verification
REQ-032 Scenario: map_valid=1 with 5 beats, the last with last=1, at (0,0) through (4,0), color 3'b111, spr idle. Required: plot=1 for 5 consecutive cycles starting 2 cycles after valid; grant 01→00.
REQ-033 Scenario: map_valid and spr_valid both rise in the same cycle. Required: grant=01 first. After the map last beat, grant=10 directly with no IDLE cycle.
REQ-034 Scenario: map streams 40 pixels continuously while spr_valid=1 with 4 pixels. Required:
  - sequence is 16 map pixels, then the 4 sprite pixels, then map resumes;
  - no pixel lost; map pixel 17 is (16,y).
REQ-035 Scenario: sprite beat at (320,10). Required: plot stays 0, dropped=1 for one cycle, spr_ready stays 1, and the next beat (5,5) plots normally.
REQ-036 Scenario: resetn=0 asserted mid-burst after 3 of 8 map beats. Required: next cycle plot=0, grant=00, X=0, Y=0. After release, map is re-granted and new beats are plotted.
REQ-037 Scenario: in MAP, map_valid drops for 3 cycles with spr idle, then resumes. Required: grant holds 01, plot=0 during the gap, counter is unchanged.
